// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared constants and types for the memory bus arbiter
//
// Purpose: bus widths, FSM state encodings, the forced-completion read value
// and the request bundle type used by mem_bus_arbiter.
// Ports: none (package).

package mem_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    // Arbiter FSM state, kept as plain constants so older tools that lack
    // enum support in ports and waveforms still read them cleanly.
    typedef logic [0:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 1'b0;
    localparam arb_state_t ST_BUSY = 1'b1;

    // Read data returned to a master whose transaction was forced complete.
    localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    // One master's request as presented on the shared slave side.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } bus_req_t;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational rotate-and-scan round-robin picker
//
// Purpose: pick the first asserted request starting one position after the
// previous winner and wrapping modulo N. Purely combinational so it can be
// reused wherever a fair one-of-N choice is needed.
// Ports:
//   req      in   N            request vector
//   last     in   $clog2(N)    index of the previous winner
//   gnt_idx  out  $clog2(N)    index of the chosen requester (0 when none)
//   any_req  out  1            at least one request is asserted

module rr_priority_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any_req
);

    localparam int IW = $clog2(N);

    // Scan last+1 .. last+N; the previous winner is checked last so it only
    // wins again when nobody else is asking.
    always_comb begin
        gnt_idx = '0;
        any_req = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!any_req && req[IW'((int'(last) + k) % N)]) begin
                any_req = 1'b1;
                gnt_idx = IW'((int'(last) + k) % N);
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one native memory bus among N masters
//
// Purpose: grants one master at a time onto the slave bus. A granted
// transaction stays locked until the slave answers with s_ready (or until the
// optional timeout forces completion). One arbitration cycle is spent in IDLE
// per transaction; completion back to the master is combinational.
// Optional feature: define ARB_TIMEOUT_EN to enable the BUSY watchdog that
// forces completion with TIMEOUT_RDATA and sets the sticky timeout_err flag.
// Ports:
//   clk          in   1          system clock
//   nrst         in   1          asynchronous active-low reset
//   m_valid      in   N          per-master request
//   m_addr       in   N*32       per-master address, master i at [32*i +: 32]
//   m_wdata      in   N*32       per-master write data
//   m_wstrb      in   N*4        per-master byte strobes, 0 = read
//   m_ready      out  N          one-hot completion pulse to the granted master
//   m_rdata      out  32         read data, qualified by m_ready
//   s_valid      out  1          slave request
//   s_addr       out  32         granted master's address (0 outside BUSY)
//   s_wdata      out  32         granted master's write data (0 outside BUSY)
//   s_wstrb      out  4          granted master's strobes (0 outside BUSY)
//   s_ready      in   1          slave completion
//   s_rdata      in   32         slave read data
//   grant        out  $clog2(N)  current / last granted master
//   busy         out  1          transaction in progress
//   timeout_err  out  1          sticky forced-completion flag

module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int N              = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic [N-1:0]           m_valid,
    input  logic [N*ADDR_W-1:0]    m_addr,
    input  logic [N*DATA_W-1:0]    m_wdata,
    input  logic [N*STRB_W-1:0]    m_wstrb,
    output logic [N-1:0]           m_ready,
    output logic [DATA_W-1:0]      m_rdata,
    output logic                   s_valid,
    output logic [ADDR_W-1:0]      s_addr,
    output logic [DATA_W-1:0]      s_wdata,
    output logic [STRB_W-1:0]      s_wstrb,
    input  logic                   s_ready,
    input  logic [DATA_W-1:0]      s_rdata,
    output logic [$clog2(N)-1:0]   grant,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int GW = $clog2(N);

    arb_state_t    state;
    logic [GW-1:0] last;

    logic [GW-1:0] pick_idx;
    logic          pick_any;

    logic          valid_g;
    bus_req_t      req_g;

    logic          done_ok;
    logic          force_done;
    logic          finish;
    logic          abort;

    rr_priority_pick #(
        .N (N)
    ) u_pick (
        .req     (m_valid),
        .last    (last),
        .gnt_idx (pick_idx),
        .any_req (pick_any)
    );

    // Select the granted master's request lines.
    always_comb begin
        valid_g = 1'b0;
        req_g   = '0;
        for (int i = 0; i < N; i++) begin
            if (GW'(i) == grant) begin
                valid_g     = m_valid[i];
                req_g.addr  = m_addr[ADDR_W*i +: ADDR_W];
                req_g.wdata = m_wdata[DATA_W*i +: DATA_W];
                req_g.wstrb = m_wstrb[STRB_W*i +: STRB_W];
            end
        end
    end

    assign busy    = (state == ST_BUSY);
    assign s_valid = busy & valid_g;
    assign s_addr  = busy ? req_g.addr  : '0;
    assign s_wdata = busy ? req_g.wdata : '0;
    assign s_wstrb = busy ? req_g.wstrb : '0;

    assign done_ok = s_valid & s_ready;
    // The granted master withdrew its request before the slave answered.
    assign abort   = busy & ~valid_g;
    assign finish  = done_ok | force_done;

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_cnt;

    assign force_done = s_valid & ~s_ready & (wait_cnt == TO_LAST);
    assign m_rdata    = force_done ? TIMEOUT_RDATA : s_rdata;

    // Held at zero while IDLE, so every BUSY period starts counting from 0.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                wait_cnt <= '0;
            end else if (!s_ready) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (force_done) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign force_done  = 1'b0;
    assign m_rdata     = s_rdata;
    // TIMEOUT_CYCLES has no effect in this build; the flag is a constant 0.
    assign timeout_err = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        m_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (GW'(i) == grant) begin
                m_ready[i] = finish;
            end
        end
    end

    // last starts at N-1 so the first grant after reset goes to master 0.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= ST_IDLE;
            grant <= '0;
            last  <= GW'(N - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant <= pick_idx;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (finish) begin
                        last  <= grant;
                        state <= ST_IDLE;
                    end else if (abort) begin
                        // Aborted transactions do not advance the rotation.
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed scoreboard testbench for mem_bus_arbiter

module tb_mem_bus_arbiter;

    localparam int          N        = 2;
    localparam int          TO_CYC   = 8;
    localparam logic [31:0] LED_ADDR = 32'h4000_0000;

    typedef struct {
        int          master;
        bit          is_read;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    logic            clk;
    logic            nrst;
    logic [N-1:0]    m_valid;
    logic [N*32-1:0] m_addr;
    logic [N*32-1:0] m_wdata;
    logic [N*4-1:0]  m_wstrb;
    logic [N-1:0]    m_ready;
    logic [31:0]     m_rdata;
    logic            s_valid;
    logic [31:0]     s_addr;
    logic [31:0]     s_wdata;
    logic [3:0]      s_wstrb;
    logic            s_ready;
    logic [31:0]     s_rdata;
    logic [0:0]      grant;
    logic            busy;
    logic            timeout_err;

    exp_t         sb[$];
    req_t         pend0[$];
    req_t         pend1[$];
    logic [N-1:0] done_pend;
    logic [N-1:0] abort_req;
    logic [7:0]   led;
    int           n_vec;
    int           n_err;
    int           n_done;
    int           slave_lat;
    int           wait_cnt;

    mem_bus_arbiter #(
        .N              (N),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .m_valid     (m_valid),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_ready     (m_ready),
        .m_rdata     (m_rdata),
        .s_valid     (s_valid),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_ready     (s_ready),
        .s_rdata     (s_rdata),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0] ^ 16'hC0DE, ~addr[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input int m, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input bit track);
        req_t r;
        exp_t e;
        r.addr  = addr;
        r.wdata = wdata;
        r.wstrb = wstrb;
        if (m == 0) pend0.push_back(r);
        else        pend1.push_back(r);
        if (track) begin
            e.master  = m;
            e.is_read = (wstrb == 4'b0000);
            e.rdata   = addr[31] ? 32'hDEAD_BEEF : mem_word(addr);
            sb.push_back(e);
        end
    endtask

    task automatic load(input int i, input req_t r);
        m_addr[32*i +: 32]  = r.addr;
        m_wdata[32*i +: 32] = r.wdata;
        m_wstrb[4*i +: 4]   = r.wstrb;
        m_valid[i]          = 1'b1;
    endtask

    // Rising edge, then masters update, then the slave model reacts.
    task automatic edge_and_drive();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (done_pend[i] || abort_req[i]) begin
                m_valid[i]   = 1'b0;
                done_pend[i] = 1'b0;
                abort_req[i] = 1'b0;
            end else if (!m_valid[i]) begin
                if (i == 0 && pend0.size() > 0) load(i, pend0.pop_front());
                if (i == 1 && pend1.size() > 0) load(i, pend1.pop_front());
            end
        end
        #1;
        if (s_valid === 1'b1 && s_addr[31] === 1'b0) begin
            if (wait_cnt >= slave_lat) begin
                s_ready  = 1'b1;
                wait_cnt = 0;
                if (s_wstrb == 4'b0000) begin
                    s_rdata = mem_word(s_addr);
                end else begin
                    s_rdata = 32'h0;
                    if (s_addr == LED_ADDR && s_wstrb[0]) led = s_wdata[7:0];
                end
            end else begin
                s_ready  = 1'b0;
                s_rdata  = 32'h0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            s_ready  = 1'b0;
            s_rdata  = 32'h0;
            wait_cnt = 0;
        end
    endtask

    task automatic sample();
        exp_t e;
        @(negedge clk);
        if (m_ready !== '0) begin
            n_done++;
            done_pend = done_pend | m_ready;
            if (sb.size() == 0) begin
                chk("unexpected_ready", 32'(m_ready), 32'h0);
            end else begin
                e = sb.pop_front();
                chk("ready_onehot", 32'(m_ready), 32'(1) << e.master);
                if (e.is_read) chk("rdata", m_rdata, e.rdata);
            end
        end
    endtask

    task automatic cycle();
        edge_and_drive();
        sample();
    endtask

    task automatic run_until_done(input string tag, input int budget, output int bc);
        int base;
        base = n_done;
        bc   = 0;
        for (int k = 0; k < budget; k++) begin
            cycle();
            if (busy === 1'b1) bc++;
            if (n_done != base) break;
        end
        chk({tag, "_completed"}, 32'(n_done != base), 32'h1);
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while ((sb.size() != 0 || pend0.size() != 0 || pend1.size() != 0 ||
                m_valid != '0 || busy !== 1'b0) && k < 300) begin
            cycle();
            k++;
        end
        chk({tag, "_drained"}, 32'(k < 300), 32'h1);
    endtask

    initial begin
        int base;
        int bc;

        nrst      = 1'b0;
        m_valid   = '0;
        m_addr    = '0;
        m_wdata   = '0;
        m_wstrb   = '0;
        s_ready   = 1'b0;
        s_rdata   = 32'h0;
        done_pend = '0;
        abort_req = '0;
        led       = 8'h00;
        n_vec     = 0;
        n_err     = 0;
        n_done    = 0;
        slave_lat = 0;
        wait_cnt  = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_s_valid", 32'(s_valid), 32'h0);
        chk("rst_m_ready", 32'(m_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_timeout_err", 32'(timeout_err), 32'h0);
        chk("rst_s_addr", s_addr, 32'h0);
        nrst = 1'b1;

        // Single read, one-cycle arbitration, one-cycle slave latency
        slave_lat = 1;
        issue(0, 32'h0000_0010, 32'h0, 4'b0000, 1'b1);
        cycle();
        chk("t1_arb_s_valid", 32'(s_valid), 32'h0);
        chk("t1_arb_busy", 32'(busy), 32'h0);
        cycle();
        chk("t1_s_valid", 32'(s_valid), 32'h1);
        chk("t1_s_addr", s_addr, 32'h0000_0010);
        chk("t1_s_wstrb", 32'(s_wstrb), 32'h0);
        chk("t1_grant", 32'(grant), 32'h0);
        base = n_done;
        cycle();
        chk("t1_ready_seen", 32'(n_done), 32'(base + 1));
        cycle();
        chk("t1_ready_once", 32'(m_ready), 32'h0);
        chk("t1_back_idle", 32'(busy), 32'h0);

        // LED write by master 1 alone
        slave_lat = 0;
        issue(1, LED_ADDR, 32'h0000_00A5, 4'b0001, 1'b1);
        drain("t3");
        chk("t3_led", 32'(led), 32'h0000_00A5);

        // Contention with last=1: 0 then 1 then 0 again
        issue(0, 32'h0000_0100, 32'h0, 4'b0000, 1'b1);
        issue(1, 32'h0000_0204, 32'h0, 4'b0000, 1'b1);
        issue(0, 32'h0000_0308, 32'h0, 4'b0000, 1'b1);
        drain("t2");

        // Lock: master 0 with 4 BUSY cycles while master 1 requests
        slave_lat = 3;
        issue(0, 32'h0000_0400, 32'h0, 4'b0000, 1'b1);
        cycle();
        issue(1, 32'h0000_0504, 32'h1234_5678, 4'b1111, 1'b1);
        base = n_done;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t4_grant", 32'(grant), 32'h0);
            chk("t4_s_addr", s_addr, 32'h0000_0400);
            chk("t4_busy", 32'(busy), 32'h1);
            chk("t4_ready_timing", 32'(n_done), 32'(base + ((k == 3) ? 1 : 0)));
        end
        drain("t4");

        // Abort: master 0 withdraws mid-BUSY; rotation must not advance
        slave_lat = 20;
        issue(0, 32'h0000_0600, 32'h0, 4'b0000, 1'b0);
        repeat (3) cycle();
        abort_req[0] = 1'b1;
        cycle();
        chk("ab_s_valid", 32'(s_valid), 32'h0);
        chk("ab_m_ready", 32'(m_ready), 32'h0);
        cycle();
        chk("ab_idle", 32'(busy), 32'h0);
        slave_lat = 0;
        issue(0, 32'h0000_0700, 32'h0, 4'b0000, 1'b1);
        issue(1, 32'h0000_0804, 32'h0, 4'b0000, 1'b1);
        drain("ab");

`ifdef ARB_TIMEOUT_EN
        // Timeout on an unmapped address
        issue(0, 32'h8000_0000, 32'h0, 4'b0000, 1'b1);
        cycle();
        run_until_done("t5", 40, bc);
        chk("t5_busy_cycles", 32'(bc), 32'(TO_CYC));
        cycle();
        chk("t5_timeout_err", 32'(timeout_err), 32'h1);
        chk("t5_s_valid_off", 32'(s_valid), 32'h0);
        issue(1, 32'h0000_0900, 32'h0, 4'b0000, 1'b1);
        drain("t5");
        chk("t5_sticky", 32'(timeout_err), 32'h1);
`else
        // Without the watchdog a slow slave is simply waited for
        slave_lat = 12;
        issue(0, 32'h0000_0A00, 32'h0, 4'b0000, 1'b1);
        cycle();
        run_until_done("t5", 40, bc);
        chk("t5_busy_cycles", 32'(bc), 32'd13);
        chk("t5_no_timeout", 32'(timeout_err), 32'h0);
        drain("t5");
`endif

        // Asynchronous reset during a completing BUSY cycle
        slave_lat = 2;
        issue(1, 32'h0000_0B00, 32'h0, 4'b0000, 1'b0);
        repeat (3) cycle();
        edge_and_drive();
        #1;
        chk("t6_pre_ready", 32'(m_ready), 32'h2);
        chk("t6_pre_grant", 32'(grant), 32'h1);
        nrst = 1'b0;
        #1;
        chk("t6_s_valid", 32'(s_valid), 32'h0);
        chk("t6_m_ready", 32'(m_ready), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_grant", 32'(grant), 32'h0);
        chk("t6_timeout_err", 32'(timeout_err), 32'h0);
        m_valid   = '0;
        done_pend = '0;
        abort_req = '0;
        s_ready   = 1'b0;
        s_rdata   = 32'h0;
        wait_cnt  = 0;
        repeat (2) @(negedge clk);
        nrst      = 1'b1;
        slave_lat = 0;
        issue(0, 32'h0000_0C00, 32'h0, 4'b0000, 1'b1);
        issue(1, 32'h0000_0C04, 32'h0, 4'b0000, 1'b1);
        drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
